// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int FETCH_PC_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {F_RUN, F_HALT} fetch_state_e;
  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry queue, slot 0 is always the head
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);
  localparam fetch_entry_t EMPTY = '{pc: '0, instr: NOP_INSTR};
  fetch_entry_t s0_q, s0_d, s1_q, s1_d;
  logic [1:0] cnt_q, cnt_d, lvl;
  // pop shifts slot 1 forward, then the push lands in the first free slot
  always_comb begin
    lvl = cnt_q - {1'b0, pop_i};
    s0_d = pop_i ? s1_q : s0_q;
    s1_d = s1_q;
    if (push_i && lvl == 2'd0) s0_d = din_i;
    if (push_i && lvl == 2'd1) s1_d = din_i;
    cnt_d = flush_i ? 2'd0 : lvl + {1'b0, push_i};
  end
  // storage and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q  <= EMPTY;
      s1_q  <= EMPTY;
      cnt_q <= 2'd0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      cnt_q <= cnt_d;
    end
  end
  assign count_o = cnt_q;
  assign head_o  = s0_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, read issue, in-flight tag and halt FSM feeding a 2-entry queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  input  logic            halt_i,
  output logic            imem_en_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [PC_W-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            halted_o
);
  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;
  logic            pop, redir, push;
  logic [1:0]      count;
  logic [2:0]      occ;
  fetch_entry_t    din, head;
  assign pop   = if_valid_o && if_ready_i;
  assign redir = redirect_i && !halt_i && state_q == F_RUN;
  assign push  = req_valid_q && !redir;
  assign occ   = {1'b0, count} + {2'b0, req_valid_q};
  assign imem_en_o = state_q == F_RUN && !reset && !redirect_i && !halt_i && (occ < 3'd2 || pop);
  assign din = '{pc: FETCH_PC_W'(req_pc_q), instr: imem_rdata_i};
  // next PC and in-flight tag; a redirect kills the read and issues nothing
  always_comb begin
    pc_d        = redir ? {redirect_pc_i[PC_W-1:2], 2'b00} : imem_en_o ? pc_q + PC_W'(4) : pc_q;
    req_valid_d = imem_en_o;
    req_pc_d    = imem_en_o ? pc_q : req_pc_q;
  end
  // PC and in-flight registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end
  // run/halt FSM; halt is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= F_RUN;
    else if (halt_i) state_q <= F_HALT;
  end
  fetch_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .flush_i (redir),
    .count_o (count),
    .head_o  (head)
  );
  assign imem_addr_o = pc_q;
  assign if_valid_o  = count != 2'd0;
  assign if_pc_o     = PC_W'(head.pc);
  assign if_instr_o  = head.instr;
  assign halted_o    = state_q == F_HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        imem_en_o;
  logic [8:0]  imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [8:0]  if_pc_o;
  logic [31:0] if_instr_o;
  logic        halted_o;
  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory: data tagged with its address
  always @(posedge clk)
    imem_rdata_i <= imem_en_o ? ({23'b0, imem_addr_o} | 32'hA000_0000) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back((start + 32'(4 * i)) & 32'h1FF);
  endtask

  // every handshake must deliver the next expected instruction
  always @(negedge clk) begin
    if (!reset) begin
      chk("occupancy_le2", 32'((32'(dut.u_fifo.cnt_q) + 32'(dut.req_valid_q)) <= 2), 32'd1);
      if (if_valid_o && if_ready_i) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("head_pc", {23'b0, if_pc_o}, e);
          chk("head_instr", if_instr_o, e | 32'hA000_0000);
        end
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_valid", {31'b0, if_valid_o}, 0);
    chk("rst_en", {31'b0, imem_en_o}, 0);
    chk("rst_halted", {31'b0, halted_o}, 0);
    chk("rst_if_pc", {23'b0, if_pc_o}, 0);
    chk("rst_instr", if_instr_o, 32'h00000013);
    chk("rst_addr", {23'b0, imem_addr_o}, 0);
    sb_load(0, 64);
    reset = 1'b0;
    #1;
    chk("first_en", {31'b0, imem_en_o}, 1);
    chk("first_addr", {23'b0, imem_addr_o}, 0);
    tick(1);
    chk("lat_valid_c1", {31'b0, if_valid_o}, 0);
    chk("addr_c1", {23'b0, imem_addr_o}, 4);
    tick(1);
    chk("lat_valid_c2", {31'b0, if_valid_o}, 1);
    chk("lat_pc_c2", {23'b0, if_pc_o}, 0);
    chk("lat_instr_c2", if_instr_o, 32'hA000_0000);
    tick(4);
    if_ready_i = 1'b0;
    #1;
    chk("bp_en_first", {31'b0, imem_en_o}, 0);
    tick(4);
    chk("bp_en", {31'b0, imem_en_o}, 0);
    chk("bp_addr", {23'b0, imem_addr_o}, 24);
    chk("bp_head", {23'b0, if_pc_o}, 16);
    chk("bp_count", {30'b0, dut.u_fifo.cnt_q}, 2);
    if_ready_i = 1'b1;
    #1;
    chk("bp_release_en", {31'b0, imem_en_o}, 1);
    tick(2);
    chk("resume_head", {23'b0, if_pc_o}, 24);
    if_ready_i = 1'b0;
    tick(1);
    chk("full_count", {30'b0, dut.u_fifo.cnt_q}, 2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0043;
    sb_load(32'h40, 16);
    #1;
    chk("redir_en", {31'b0, imem_en_o}, 0);
    tick(1);
    redirect_i = 1'b0;
    if_ready_i = 1'b1;
    #1;
    chk("redir_r1_valid", {31'b0, if_valid_o}, 0);
    chk("redir_r1_addr", {23'b0, imem_addr_o}, 32'h40);
    chk("redir_r1_en", {31'b0, imem_en_o}, 1);
    tick(1);
    chk("redir_r2_valid", {31'b0, if_valid_o}, 0);
    tick(1);
    chk("redir_r3_valid", {31'b0, if_valid_o}, 1);
    chk("redir_r3_pc", {23'b0, if_pc_o}, 32'h40);
    tick(2);
    halt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    #1;
    chk("halt_en", {31'b0, imem_en_o}, 0);
    tick(1);
    halt_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk("halted_set", {31'b0, halted_o}, 1);
    chk("halt_pc_held", {23'b0, imem_addr_o}, 32'h50);
    chk("halt_no_en", {31'b0, imem_en_o}, 0);
    chk("halt_drain_pc", {23'b0, if_pc_o}, 32'h4C);
    tick(1);
    chk("halt_drained", {31'b0, if_valid_o}, 0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0080;
    tick(1);
    redirect_i = 1'b0;
    chk("halt_redir_ignored", {23'b0, imem_addr_o}, 32'h50);
    tick(3);
    chk("halt_sticky", {31'b0, halted_o}, 1);
    chk("halt_sticky_en", {31'b0, imem_en_o}, 0);
    reset = 1'b1;
    tick(1);
    chk("rst_clears_halt", {31'b0, halted_o}, 0);
    sb_load(32'h1FC, 16);
    reset = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_01FC;
    #1;
    chk("wrap_redir_en", {31'b0, imem_en_o}, 0);
    tick(1);
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr_top", {23'b0, imem_addr_o}, 32'h1FC);
    chk("wrap_en_top", {31'b0, imem_en_o}, 1);
    tick(1);
    chk("wrap_addr_zero", {23'b0, imem_addr_o}, 0);
    chk("wrap_en_zero", {31'b0, imem_en_o}, 1);
    tick(1);
    chk("wrap_head_top", {23'b0, if_pc_o}, 32'h1FC);
    tick(1);
    chk("wrap_head_zero", {23'b0, if_pc_o}, 0);
    chk("mid_inflight", {31'b0, dut.req_valid_q}, 1);
    if_ready_i = 1'b0;
    reset = 1'b1;
    sb_load(0, 16);
    tick(1);
    chk("mid_rst_valid", {31'b0, if_valid_o}, 0);
    chk("mid_rst_instr", if_instr_o, 32'h00000013);
    chk("mid_rst_addr", {23'b0, imem_addr_o}, 0);
    reset = 1'b0;
    if_ready_i = 1'b1;
    #1;
    chk("restart_en", {31'b0, imem_en_o}, 1);
    tick(1);
    chk("no_stale_push", {31'b0, if_valid_o}, 0);
    tick(1);
    chk("restart_head", {23'b0, if_pc_o}, 0);
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
